// File: rtl/block_chain.sv
// block_chain: handshake-to-handshake elastic buffer.
// Upstream pushes are accepted on a req_in/ack_out handshake, buffered in a
// small circular store, and offered downstream one at a time on req_out/ack_in.
// PHASE selects transition (2) or return-to-zero (4) signalling on both sides.
module block_chain #(
    parameter int DATA_WIDTH  = 3,
    parameter int DEPTH       = 4,
    parameter int PHASE       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_in,
    output logic                         ack_out,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         req_out,
    input  logic                         ack_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic rs;
    logic as;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rs = req_in;
            assign as = ack_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
            logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

            // Shift chain: stage 0 samples the pin, the last stage is used.
            always_comb begin
                req_sync_d    = req_sync_q;
                ack_sync_d    = ack_sync_q;
                req_sync_d[0] = req_in;
                ack_sync_d[0] = ack_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    req_sync_d[i] = req_sync_q[i-1];
                    ack_sync_d[i] = ack_sync_q[i-1];
                end
            end

            // Synchroniser flops, cleared by reset so no stray edge is seen.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_sync_q <= '0;
                    ack_sync_q <= '0;
                end else begin
                    req_sync_q <= req_sync_d;
                    ack_sync_q <= ack_sync_d;
                end
            end

            assign rs = req_sync_q[SYNC_STAGES-1];
            assign as = ack_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic                  ack_out_q, ack_out_d;
    logic                  req_out_q, req_out_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic push_pend;
    logic ack_clr;
    logic pop;
    logic idle;
    logic offer;
    logic push;

    // Handshake decode and next-state for both sides of the buffer.
    // busy_q marks an outstanding downstream offer; in PHASE 2 it is what
    // tells "acknowledged" apart from "never requested" when req_out==as.
    always_comb begin
        push_pend = (PHASE == 4) ? (rs && !ack_out_q) : (rs != ack_out_q);
        ack_clr   = (PHASE == 4) && !rs && ack_out_q;
        pop       = busy_q && ((PHASE == 4) ? as : (as == req_out_q));
        idle      = !busy_q && ((PHASE == 4) ? !as : (req_out_q == as));
        offer     = idle && (count_q != '0);
        push      = push_pend && ((count_q < CW'(DEPTH)) || pop);

        ack_out_d  = ack_out_q;
        req_out_d  = req_out_q;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (push) begin
            ack_out_d = (PHASE == 4) ? 1'b1 : !ack_out_q;
            wr_ptr_d  = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end else if (ack_clr) begin
            ack_out_d = 1'b0;
        end

        if (offer) begin
            req_out_d  = (PHASE == 4) ? 1'b1 : !req_out_q;
            data_out_d = mem_q[rd_ptr_q];
            busy_d     = 1'b1;
        end else if (pop) begin
            if (PHASE == 4) req_out_d = 1'b0;
            busy_d   = 1'b0;
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_out_q  <= 1'b0;
            req_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            data_out_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            ack_out_q  <= ack_out_d;
            req_out_q  <= req_out_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload store; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    assign ack_out  = ack_out_q;
    assign req_out  = req_out_q;
    assign data_out = data_out_q;
    assign count    = count_q;

endmodule

// File: tb/tb_block_chain.sv
// Directed bench for block_chain: three instances (PHASE 2 / DEPTH 4,
// PHASE 4 / DEPTH 4, PHASE 2 / DEPTH 3) sharing clock and reset.
module tb_block_chain;

    localparam int TMO = 1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       req_in2, ack_out2, req_out2, ack_in2;
    logic [2:0] data_in2, data_out2, count2;
    logic       req_in4, ack_out4, req_out4, ack_in4;
    logic [2:0] data_in4, data_out4, count4;
    logic       req_in3, ack_out3, req_out3, ack_in3;
    logic [2:0] data_in3, data_out3;
    logic [1:0] count3;

    block_chain #(.DATA_WIDTH(3), .DEPTH(4), .PHASE(2), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req_in(req_in2), .ack_out(ack_out2),
        .data_in(data_in2), .req_out(req_out2), .ack_in(ack_in2),
        .data_out(data_out2), .count(count2));

    block_chain #(.DATA_WIDTH(3), .DEPTH(4), .PHASE(4), .SYNC_STAGES(2)) u4 (
        .clk(clk), .rst_n(rst_n), .req_in(req_in4), .ack_out(ack_out4),
        .data_in(data_in4), .req_out(req_out4), .ack_in(ack_in4),
        .data_out(data_out4), .count(count4));

    block_chain #(.DATA_WIDTH(3), .DEPTH(3), .PHASE(2), .SYNC_STAGES(1)) u3 (
        .clk(clk), .rst_n(rst_n), .req_in(req_in3), .ack_out(ack_out3),
        .data_in(data_in3), .req_out(req_out3), .ack_in(ack_in3),
        .data_out(data_out3), .count(count3));

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];
    logic prod_done, cons_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_in2 = 0; ack_in2 = 0; data_in2 = 0;
        req_in4 = 0; ack_in4 = 0; data_in4 = 0;
        req_in3 = 0; ack_in3 = 0; data_in3 = 0;
        prod_done = 0; cons_done = 0;
        #12;
        check("rst_ack2", ack_out2, 0);
        check("rst_req2", req_out2, 0);
        check("rst_data2", data_out2, 0);
        check("rst_cnt2", count2, 0);
        check("rst_req4", req_out4, 0);
        check("rst_cnt3", count3, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);

        // PHASE 2 fill: four pushes acked, fifth waits while full
        for (int i = 1; i <= 4; i++) begin
            data_in2 = 3'(i);
            req_in2  = ~req_in2;
            tick(2);
            check("fill_ack_hold", ack_out2, (i - 1) & 1);
            tick(1);
            check("fill_ack_tog", ack_out2, i & 1);
            check("fill_cnt", count2, i);
        end
        data_in2 = 3'd5;
        req_in2  = ~req_in2;
        tick(5);
        check("full_ack_hold", ack_out2, 0);
        check("full_cnt", count2, 4);
        check("full_req_out", req_out2, 1);
        check("full_data_out", data_out2, 1);

        // pop of 1 and push of 5 on the same edge
        ack_in2 = 1'b1;
        tick(2);
        check("pp_ack_before", ack_out2, 0);
        check("pp_cnt_before", count2, 4);
        tick(1);
        check("pp_ack_after", ack_out2, 1);
        check("pp_cnt_after", count2, 4);
        check("pp_req_idle", req_out2, 1);
        tick(1);
        check("pp_req_next", req_out2, 0);
        check("pp_data_next", data_out2, 2);
        check("pp_cnt_next", count2, 4);

        // pop 2 -> count 3 with item 3 offered, then reset mid-transfer
        ack_in2 = 1'b0;
        tick(3);
        check("pre_rst_cnt", count2, 3);
        tick(1);
        check("pre_rst_req", req_out2, 1);
        check("pre_rst_data", data_out2, 3);
        rst_n = 1'b0;
        req_in2 = 1'b0;
        ack_in2 = 1'b0;
        #1;
        check("mid_rst_ack", ack_out2, 0);
        check("mid_rst_req", req_out2, 0);
        check("mid_rst_data", data_out2, 0);
        check("mid_rst_cnt", count2, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        data_in2 = 3'd7;
        req_in2  = 1'b1;
        tick(3);
        check("post_rst_ack", ack_out2, 1);
        check("post_rst_cnt", count2, 1);
        tick(1);
        check("post_rst_req", req_out2, 1);
        check("post_rst_data", data_out2, 7);
        ack_in2 = 1'b1;
        tick(3);
        check("post_rst_drain", count2, 0);

        // PHASE 4 single transfer with latency checks
        data_in4 = 3'd6;
        req_in4  = 1'b1;
        tick(2);
        check("p4_ack_hold", ack_out4, 0);
        tick(1);
        check("p4_ack_set", ack_out4, 1);
        check("p4_cnt", count4, 1);
        check("p4_req_wait", req_out4, 0);
        tick(1);
        check("p4_req_set", req_out4, 1);
        check("p4_data", data_out4, 6);
        req_in4 = 1'b0;
        tick(2);
        check("p4_ack_still", ack_out4, 1);
        tick(1);
        check("p4_ack_clr", ack_out4, 0);
        ack_in4 = 1'b1;
        tick(2);
        check("p4_req_hold", req_out4, 1);
        tick(1);
        check("p4_req_clr", req_out4, 0);
        check("p4_cnt_pop", count4, 0);
        ack_in4 = 1'b0;
        tick(3);

        // PHASE 2 random stream
        exp_q.delete();
        prod_done = 0; cons_done = 0;
        fork
            begin : prod2
                int to;
                logic prev;
                for (int i = 0; i < 200; i++) begin
                    data_in2 = 3'($urandom_range(0, 7));
                    exp_q.push_back(data_in2);
                    prev = ack_out2;
                    req_in2 = ~req_in2;
                    to = 0;
                    while (ack_out2 == prev && to < TMO) begin tick(1); to++; end
                    if (to >= TMO) check("s2_push_tmo", to, 0);
                    tick($urandom_range(0, 3));
                end
                prod_done = 1;
            end
            begin : cons2
                int to;
                logic [2:0] e;
                for (int i = 0; i < 200; i++) begin
                    to = 0;
                    while (req_out2 == ack_in2 && to < TMO) begin tick(1); to++; end
                    if (to >= TMO) check("s2_pop_tmo", to, 0);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
                    check("s2_data", data_out2, e);
                    tick($urandom_range(0, 4));
                    ack_in2 = req_out2;
                end
                cons_done = 1;
            end
            begin : mon2
                int n;
                n = 0;
                while (!cons_done && n < 20000) begin
                    check("s2_cnt_le_depth", count2 <= 3'd4, 1);
                    tick(1);
                    n++;
                end
            end
        join
        tick(4);
        check("s2_end_cnt", count2, 0);

        // PHASE 4 random stream
        exp_q.delete();
        prod_done = 0; cons_done = 0;
        fork
            begin : prod4
                int to;
                for (int i = 0; i < 200; i++) begin
                    data_in4 = 3'($urandom_range(0, 7));
                    exp_q.push_back(data_in4);
                    req_in4 = 1'b1;
                    to = 0;
                    while (!ack_out4 && to < TMO) begin tick(1); to++; end
                    if (to >= TMO) check("s4_ack_tmo", to, 0);
                    req_in4 = 1'b0;
                    to = 0;
                    while (ack_out4 && to < TMO) begin tick(1); to++; end
                    if (to >= TMO) check("s4_rtz_tmo", to, 0);
                    tick($urandom_range(0, 3));
                end
                prod_done = 1;
            end
            begin : cons4
                int to;
                logic [2:0] e;
                for (int i = 0; i < 200; i++) begin
                    to = 0;
                    while (!req_out4 && to < TMO) begin tick(1); to++; end
                    if (to >= TMO) check("s4_req_tmo", to, 0);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bx;
                    check("s4_data", data_out4, e);
                    tick($urandom_range(0, 4));
                    ack_in4 = 1'b1;
                    to = 0;
                    while (req_out4 && to < TMO) begin tick(1); to++; end
                    if (to >= TMO) check("s4_rclr_tmo", to, 0);
                    ack_in4 = 1'b0;
                end
                cons_done = 1;
            end
            begin : mon4
                int n;
                n = 0;
                while (!cons_done && n < 20000) begin
                    check("s4_cnt_le_depth", count4 <= 3'd4, 1);
                    tick(1);
                    n++;
                end
            end
        join
        tick(4);
        check("s4_end_cnt", count4, 0);

        // DEPTH 3: ten push/pop rounds wrap both pointers several times
        for (int i = 0; i < 10; i++) begin
            int to;
            logic [2:0] v;
            v = 3'((i * 3 + 1) % 8);
            data_in3 = v;
            req_in3  = ~req_in3;
            to = 0;
            while (ack_out3 != req_in3 && to < TMO) begin tick(1); to++; end
            if (to >= TMO) check("d3_ack_tmo", to, 0);
            to = 0;
            while (req_out3 == ack_in3 && to < TMO) begin tick(1); to++; end
            if (to >= TMO) check("d3_req_tmo", to, 0);
            check("d3_data", data_out3, v);
            ack_in3 = req_out3;
        end
        tick(3);
        check("d3_end_cnt", count3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
